// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the sequential MixColumns engine: one 128-bit state in, one out.
// The engine side uses the slave modport; the round controller uses master.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         inv_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport master (
    output in_valid,
    output data_in,
    output inv_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  inv_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns
// per BUSY cycle, with valid/ready handshakes on both sides.
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst_n,
  mix_columns_seq_if.slave bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gen_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned NumSteps = (COLS_PER_CYCLE == 4) ? 1 :
                                     (COLS_PER_CYCLE == 2) ? 2 : 4;
  localparam int unsigned Shift    = (COLS_PER_CYCLE == 4) ? 2 :
                                     (COLS_PER_CYCLE == 2) ? 1 : 0;
  localparam logic [1:0]  LastCnt  = 2'(NumSteps - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

  fsm_e         fsm_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         mode_q;
  logic [1:0]   col_cnt_q;
  logic [127:0] state_q;
  logic [127:0] result_q;
  logic [127:0] result_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix, built from xtime chains.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    logic [1:0]  k1;
    logic [1:0]  k2;
    logic [1:0]  k3;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      k1 = 2'(r + 1);
      k2 = 2'(r + 2);
      k3 = 2'(r + 3);
      if (!inv) begin
        res[8*r +: 8] = x2[r] ^ (x2[k1] ^ a[k1]) ^ a[k2] ^ a[k3];
      end else begin
        res[8*r +: 8] = (x8[r]  ^ x4[r]  ^ x2[r])    // 0e
                      ^ (x8[k1] ^ x2[k1] ^ a[k1])    // 0b
                      ^ (x8[k2] ^ x4[k2] ^ a[k2])    // 0d
                      ^ (x8[k3] ^ a[k3]);            // 09
      end
    end
    return res;
  endfunction

  always_comb begin
    result_d = result_q;
    for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
      logic [1:0] idx;
      idx = 2'(col_cnt_q << Shift) + 2'(j);
      result_d[{idx, 5'd0} +: 32] = mix_col(state_q[{idx, 5'd0} +: 32], mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      col_cnt_q   <= 2'd0;
      state_q     <= '0;
      result_q    <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.in_valid) begin
            state_q    <= bus.data_in;
            mode_q     <= bus.inv_mode;
            col_cnt_q  <= 2'd0;
            in_ready_q <= 1'b0;
            fsm_q      <= StBusy;
          end
        end
        StBusy: begin
          result_q  <= result_d;
          col_cnt_q <= col_cnt_q + 2'd1;
          if (col_cnt_q == LastCnt) begin
            out_valid_q <= 1'b1;
            fsm_q       <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= StIdle;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  // Gated by rst_n so the engine never advertises ready while held in reset.
  assign bus.in_ready  = in_ready_q & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = result_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) side by side.
module tb_mix_columns_seq;

  localparam logic [127:0] V1In  = 128'h00000000_00000000_00000000_455313db;
  localparam logic [127:0] V1Out = 128'h00000000_00000000_00000000_bca14d8e;
  localparam logic [127:0] V2In  = 128'hd5d4d4d4_c6c6c6c6_01010101_5c220af2;
  localparam logic [127:0] V2Out = 128'hd6d7d5d5_c6c6c6c6_01010101_9d58dc9f;

  logic         clk;
  logic         rst_n;
  logic         iv1, iv2, iv4;
  logic [127:0] d1, d2, d4;
  logic         inv_mode;
  logic         out_ready;
  int           cyc;
  int           n_checks;
  int           n_errs;

  mix_columns_seq_if bus1 ();
  mix_columns_seq_if bus2 ();
  mix_columns_seq_if bus4 ();

  assign bus1.in_valid  = iv1;
  assign bus1.data_in   = d1;
  assign bus1.inv_mode  = inv_mode;
  assign bus1.out_ready = out_ready;
  assign bus2.in_valid  = iv2;
  assign bus2.data_in   = d2;
  assign bus2.inv_mode  = inv_mode;
  assign bus2.out_ready = out_ready;
  assign bus4.in_valid  = iv4;
  assign bus4.data_in   = d4;
  assign bus4.inv_mode  = inv_mode;
  assign bus4.out_ready = out_ready;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one block on all three instances at the same edge, record latency, then drain.
  task automatic run_blk(input logic [127:0] x1, input logic [127:0] x2, input logic [127:0] x4,
                         input logic mode,
                         output logic [127:0] r1, output logic [127:0] r2,
                         output logic [127:0] r4,
                         output int l1, output int l2, output int l4);
    @(negedge clk);
    d1 = x1; d2 = x2; d4 = x4; inv_mode = mode;
    iv1 = 1'b1; iv2 = 1'b1; iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
    l1 = -1; l2 = -1; l4 = -1;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk);
      #1;
      if (l1 < 0 && bus1.out_valid) l1 = t;
      if (l2 < 0 && bus2.out_valid) l2 = t;
      if (l4 < 0 && bus4.out_valid) l4 = t;
    end
    r1 = bus1.data_out; r2 = bus2.data_out; r4 = bus4.data_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  logic [127:0] r1, r2, r4, f1, f2, f4, rnd1, rnd2, rnd4, hold;
  int           l1, l2, l4;
  int           acc [4];
  logic [127:0] pv  [4];
  logic [127:0] pe  [4];
  logic         pm  [4];
  logic         got, seen, stale, bad_bp;

  initial begin
    n_checks = 0; n_errs = 0;
    rst_n = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
    d1 = '0; d2 = '0; d4 = '0; inv_mode = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", bus1.in_ready, 1'b0);
    check_eq("rst_out_valid", bus1.out_valid, 1'b0);
    check_eq("rst_data_out1", bus1.data_out, '0);
    check_eq("rst_data_out4", bus4.data_out, '0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_ready", bus1.in_ready, 1'b1);

    // Single column forward, latency per parallelism
    run_blk(V1In, V1In, V1In, 1'b0, r1, r2, r4, l1, l2, l4);
    check_eq("col_fwd_c1", r1, V1Out);
    check_eq("col_fwd_c2", r2, V1Out);
    check_eq("col_fwd_c4", r4, V1Out);
    check_eq("lat_c1", l1, 4);
    check_eq("lat_c2", l2, 2);
    check_eq("lat_c4", l4, 1);
    check_eq("idle_after_xfer", bus1.in_ready, 1'b1);
    check_eq("ov_after_xfer", bus1.out_valid, 1'b0);

    // Full state forward, then inverse round trip
    run_blk(V2In, V2In, V2In, 1'b0, r1, r2, r4, l1, l2, l4);
    check_eq("full_fwd_c1", r1, V2Out);
    check_eq("full_fwd_c2", r2, V2Out);
    check_eq("full_fwd_c4", r4, V2Out);
    run_blk(V2Out, V2Out, V2Out, 1'b1, r1, r2, r4, l1, l2, l4);
    check_eq("full_inv_c1", r1, V2In);
    check_eq("full_inv_c2", r2, V2In);
    check_eq("full_inv_c4", r4, V2In);
    check_eq("inv_lat_c1", l1, 4);
    run_blk(V1Out, V1Out, V1Out, 1'b1, r1, r2, r4, l1, l2, l4);
    check_eq("col_inv_c1", r1, V1In);
    check_eq("col_inv_c2", r2, V1In);
    check_eq("col_inv_c4", r4, V1In);

    // Random round trips
    for (int i = 0; i < 1000; i++) begin
      rnd1 = {$urandom, $urandom, $urandom, $urandom};
      rnd2 = {$urandom, $urandom, $urandom, $urandom};
      rnd4 = {$urandom, $urandom, $urandom, $urandom};
      run_blk(rnd1, rnd2, rnd4, 1'b0, f1, f2, f4, l1, l2, l4);
      run_blk(f1, f2, f4, 1'b1, r1, r2, r4, l1, l2, l4);
      check_eq("rand_rt_c1", r1, rnd1);
      check_eq("rand_rt_c2", r2, rnd2);
      check_eq("rand_rt_c4", r4, rnd4);
    end

    // Backpressure on the single-column instance
    @(negedge clk);
    d1 = V2In; inv_mode = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("bp_ov_rise", bus1.out_valid, 1'b1);
    hold = bus1.data_out;
    check_eq("bp_data", hold, V2Out);
    d1 = V1In; inv_mode = 1'b1; iv1 = 1'b1;
    bad_bp = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      if (!bus1.out_valid || bus1.in_ready || bus1.data_out !== V2Out) bad_bp = 1'b1;
    end
    check_eq("bp_hold", bad_bp, 1'b0);
    check_eq("bp_data_stable", bus1.data_out, V2Out);
    iv1 = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_release_ov", bus1.out_valid, 1'b0);
    check_eq("bp_release_rdy", bus1.in_ready, 1'b1);
    stale = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus1.out_valid) stale = 1'b1;
    end
    check_eq("bp_single_xfer", stale, 1'b0);

    // Back-to-back alternating modes, out_ready tied high
    pv[0] = V1In;  pm[0] = 1'b0; pe[0] = V1Out;
    pv[1] = V1Out; pm[1] = 1'b1; pe[1] = V1In;
    pv[2] = V2In;  pm[2] = 1'b0; pe[2] = V2Out;
    pv[3] = V2Out; pm[3] = 1'b1; pe[3] = V2In;
    @(negedge clk);
    out_ready = 1'b1;
    d1 = pv[0]; inv_mode = pm[0]; iv1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (bus1.in_ready) begin
          @(posedge clk);
          #1;
          got = 1'b1;
        end
      end
      acc[i] = cyc;
      check_eq("pd_accept", got, 1'b1);
      if (i == 3) iv1 = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (bus1.out_valid) begin
          seen = 1'b1;
          check_eq("pd_result", bus1.data_out, pe[i]);
        end
      end
      check_eq("pd_out_seen", seen, 1'b1);
      if (i < 3) begin
        d1 = pv[i+1]; inv_mode = pm[i+1];
      end
    end
    for (int i = 1; i < 4; i++) check_eq("pd_period", acc[i] - acc[i-1], 6);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset on the second BUSY edge of a single-column block
    @(negedge clk);
    d1 = V2In; inv_mode = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_rdy", bus1.in_ready, 1'b0);
    check_eq("mid_rst_ov", bus1.out_valid, 1'b0);
    check_eq("mid_rst_do1", bus1.data_out, '0);
    check_eq("mid_rst_do2", bus2.data_out, '0);
    check_eq("mid_rst_do4", bus4.data_out, '0);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_release", bus1.in_ready, 1'b1);
    stale = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus1.out_valid || bus1.data_out !== '0) stale = 1'b1;
    end
    check_eq("mid_rst_no_stale", stale, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Sequential AES MixColumns / InvMixColumns engine for a full 128-bit state, selectable per block.
- Processes COLS_PER_CYCLE columns per clock over 4/COLS_PER_CYCLE cycles, trading area against latency.
- Sits between ShiftRows and AddRoundKey in the round datapath.
- Uses valid/ready handshakes on input and output so the round controller can stall either side.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  data_in and inv_mode are valid
in_ready  output  1  block can accept a new state
data_in  input  128  input state
inv_mode  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with data_in
out_valid  output  1  data_out holds a finished result
out_ready  input  1  downstream accepts data_out
data_out  output  128  transformed state, registered

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low on rst_n.
- Byte mapping:
  - Column c (0..3) occupies bits [32c+31:32c].
  - Row r (0..3) within a column occupies bits [8r+7:8r] of that column.
- Forward matrix, per column a0..a3 -> b0..b3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse matrix: rows 0e 0b 0d 09, rotated the same way.
- GF(2^8) arithmetic:
  - All multiplies are in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
  - Higher multipliers are built from xtime chains and XOR; no lookup tables.
- States: IDLE, BUSY, DONE. N = 4/COLS_PER_CYCLE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid=1 at an edge: latch data_in into the state register and inv_mode into the mode register, clear col_cnt, go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge transforms columns col_cnt*C .. col_cnt*C+C-1 from the state register into the result register, then increments col_cnt.
  - After the N-th BUSY edge, go to DONE.
  - Columns never transformed in the current block are not observable.
- DONE:
  - out_valid = 1, data_out = result register.
  - data_out stays stable while out_ready = 0; hold indefinitely.
  - An edge with out_ready = 1 completes the transfer and goes to IDLE.
- Timing:
  - Latency: input handshake at edge k → out_valid first high after edge k+N.
  - Minimum block period with out_ready tied high: N+2 cycles.
- Input side while not IDLE: in_valid is ignored and in_ready stays 0. data_in and inv_mode changes while not IDLE do not affect the block in flight.
- Mode is per block: inv_mode may differ between consecutive blocks.
- Reset:
  - Any edge with rst_n = 0, including mid-BUSY or in DONE, forces IDLE.
  - It also sets out_valid = 0, data_out = 0, and clears col_cnt, the state register and the mode register.
  - in_ready = 0 while rst_n = 0, and returns to 1 in the first cycle after reset deasserts.
  - A block in flight during reset is discarded; no partial output appears.
- Reset values: in_ready 0 (during reset), out_valid 0, data_out 0.

Test Plan:
- Forward, one column: data_in column0 = 0x455313db, other columns 0, inv_mode = 0 → data_out column0 = 0xbca14d8e, other columns 0. out_valid rises N edges after accept; check for C = 1, 2, 4.
- Forward, full state: columns (3..0) = 0xd5d4d4d4, 0xc6c6c6c6, 0x01010101, 0x5c220af2 → 0xd6d7d5d5, 0xc6c6c6c6, 0x01010101, 0x9d58dc9f.
- Inverse round-trip: feed each forward output from the previous scenario back in with inv_mode = 1 → the original inputs are reproduced bit-exact. Also run 1000 random states forward then inverse → identity.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_valid stays 1, data_out stable, in_ready = 0, and a new in_valid with different data is ignored. Releasing out_ready → one transfer, then IDLE.
- Mode switching back-to-back with out_ready = 1:
  - Alternate inv_mode 0/1 on consecutive blocks → each result is correct for its own latched mode.
  - Period is exactly N+2 cycles.
- Reset mid-operation: assert rst_n = 0 for 1 cycle on the second BUSY edge (C = 1) → next cycle out_valid = 0, data_out = 0, in_ready = 1 after release, and no stale output is ever presented.
